press_pulse_gen: RTL
====================

# press_pulse_gen

Converts a raw, active-low, bouncing push-button (KEY) into clean single-cycle increment requests for the score counters. It sits between the board key pins and the Increase input of each player's counter: one physical press yields exactly one Pulse, one clock wide, so a counter advances by exactly one per press. It also exposes the debounced held level for the game-control logic.

## Interface

- DEBOUNCE_CYCLES, 4: consecutive stable samples required before the debounced level changes; legal range 2..255.
- REPEAT_CYCLES, 8: auto-repeat period in cycles. Used only with PRESS_PULSE_REPEAT_EN; legal range 2..255.

- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- KeyN  input  1  raw asynchronous key, 0 = pressed.
- Enable  input  1  1 = presses may generate pulses; 0 = presses are swallowed.
- Pulse  output  1  one-cycle increment request, registered.
- Held  output  1  debounced pressed level, registered.

## Operation

- Synchronizer: two flops on KeyN, both reset to 1 (released). Only the second stage is used downstream.
- Debouncer: 8-bit stable counter compares the synced level with the debounced level.
  - Equal: counter clears to 0.
  - Differ: counter increments. When it would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears on the same edge.
  - Held = debounced pressed. Reset value 0.
- FSM, Moore, 2-bit encoding:
  - IDLE: go to FIRE if Held && Enable. Go to HOLD if Held && !Enable; that press is consumed and never pulses later.
  - FIRE: Pulse = 1. Always go to HOLD next cycle.
  - HOLD: go to IDLE when Held deasserts.
- Pulse is high only in FIRE. Reset value 0. There is never more than one Pulse per press, except in repeat mode.
- Enable is sampled only on the IDLE→FIRE decision. Dropping Enable while in FIRE does not shorten the pulse.
- Reset mid-operation: on the next edge the FSM goes to IDLE, the counters clear, and both sync flops and the debounced level go to released. Pulse and Held are 0 after that edge.
- Key held through reset release: this counts as a fresh press and produces a Pulse D+2 edges after the first post-reset edge.
- Bounce shorter than DEBOUNCE_CYCLES: the counter clears and produces no level change and no pulse.

## Timing

- Press latency: with KeyN low at edge 0 and stable, Held rises after edge DEBOUNCE_CYCLES+1 and Pulse is high for the cycle after edge DEBOUNCE_CYCLES+2. With the default of 4, Held rises at edge 5 and Pulse is high from edge 6 to edge 7.
- Release latency: Held falls after edge DEBOUNCE_CYCLES+1 of a stable high KeyN. The FSM is back in IDLE one edge later.
- Minimum press-to-press spacing: 2·DEBOUNCE_CYCLES+3 cycles.
- Throughput: at most one Pulse per press; with repeat, at most one per REPEAT_CYCLES+1 cycles.

## Configuration

- PRESS_PULSE_REPEAT_EN defined (auto-repeat on):
  - A repeat counter runs in HOLD. It clears on entry to HOLD.
  - When it reaches REPEAT_CYCLES-1, the FSM goes to FIRE if Enable is 1. If Enable is 0, it stays in HOLD, no pulse is produced, and the counter clears.
  - Release still exits to IDLE and has priority over repeat.
- PRESS_PULSE_REPEAT_EN undefined: no repeat counter, HOLD waits only for release, and REPEAT_CYCLES is ignored.

## Structure

- Shared package press_pulse_pkg holds:
  - the state typedef (IDLE=2'd0, FIRE=2'd1, HOLD=2'd2);
  - the default constants for DEBOUNCE_CYCLES and REPEAT_CYCLES;
  - the debounce counter width (8).
- One sub-module: key_debounce, containing the synchronizer and debouncer. It has inputs Clock, Reset, KeyN and output Held. The FSM and the repeat logic live in press_pulse_gen.

## Test plan

- Clean press (default parameters, Enable=1): KeyN low at edge 0 and held for 20 cycles → Held=1 from edge 5; Pulse=1 for exactly one cycle, edges 6–7; no further Pulse. Release → Held=0 after 5 edges.
- Bounce rejection: KeyN toggles low/high every 2 cycles for 12 cycles, then stays high → Held and Pulse remain 0 throughout.
- Enable gating: press with Enable=0 at the debounced edge, then raise Enable while the key is still held → no Pulse for that press. The next clean press with Enable=1 → one Pulse.
- Reset mid-press: assert Reset low in FIRE → Pulse=0 and Held=0 after the next edge. Key still held after Reset returns to 1 → one Pulse 6 edges after the first post-reset edge.
- Back-to-back presses at minimum spacing (11 cycles), 5 presses → exactly 5 Pulses; a downstream counter advances by 5.
- Repeat mode (PRESS_PULSE_REPEAT_EN, REPEAT_CYCLES=8): key held for 40 cycles after the first Pulse → further Pulses every 9 cycles. Release → Pulses stop immediately.

Source files
------------

// File: rtl/press_pulse_pkg.sv
// Shared state type and default constants for the key press-to-pulse block.
package press_pulse_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFire = 2'd1,
    StHold = 2'd2
  } press_state_e;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefRepeatCycles   = 8;
  localparam int unsigned DbCntWidth        = 8;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-sample debouncer for an active-low key.
// Held is the registered debounced pressed level.
module key_debounce
  import press_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyN,
  output logic Held
);

  localparam logic [DbCntWidth-1:0] CntLast = DbCntWidth'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  held_q, held_d;
  logic [DbCntWidth-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
    held_q  <= held_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    sync1_d = KeyN;
    sync2_d = sync1_q;
    held_d  = held_q;
    cnt_d   = '0;
    // Flip on the sample that would bring the count to DEBOUNCE_CYCLES.
    if ((~sync2_q) != held_q) begin
      if (cnt_q == CntLast) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!Reset) begin
      sync1_d = 1'b1;
      sync2_d = 1'b1;
      held_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  assign Held = held_q;

endmodule

// File: rtl/press_pulse_gen.sv
// Turns a bouncing active-low key into one single-cycle Pulse per press.
// Define PRESS_PULSE_REPEAT_EN to re-fire every REPEAT_CYCLES+1 cycles while held.
module press_pulse_gen
  import press_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyN,
  input  logic Enable,
  output logic Pulse,
  output logic Held
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_param_check
    $error("press_pulse_gen: cycle parameter out of range 2..255");
  end

  press_state_e state_q, state_d;
  logic         pulse_q, pulse_d;
  logic         held;
  logic         rpt_done;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .Clock(Clock),
    .Reset(Reset),
    .KeyN (KeyN),
    .Held (held)
  );

`ifdef PRESS_PULSE_REPEAT_EN
  localparam logic [DbCntWidth-1:0] RptLast = DbCntWidth'(REPEAT_CYCLES - 1);

  logic [DbCntWidth-1:0] rpt_q, rpt_d;

  assign rpt_done = (rpt_q == RptLast);

  // Counts only while in HOLD; a skipped repeat (Enable low) restarts the period.
  always_comb begin
    rpt_d = rpt_q + 1'b1;
    if (!Reset || state_q != StHold || rpt_done) begin
      rpt_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    rpt_q <= rpt_d;
  end
`else
  assign rpt_done = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    state_q <= state_d;
    pulse_q <= pulse_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (held) state_d = Enable ? StFire : StHold;
      StFire: state_d = StHold;
      StHold: begin
        if (!held) begin
          state_d = StIdle;
        end else if (rpt_done && Enable) begin
          state_d = StFire;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!Reset) begin
      state_d = StIdle;
    end
  end

  // Pulse registered from the next state so it is high exactly while in FIRE.
  always_comb begin
    pulse_d = (state_d == StFire);
  end

  assign Pulse = pulse_q;
  assign Held  = held;

endmodule
